// File: rtl/pma_region_check_pkg.sv
// Shared definitions for the PMA region checker: attribute bit positions,
// attribute type and region-index width helper.
package pma_region_check_pkg;

  localparam int PMA_C  = 0;
  localparam int PMA_W  = 1;
  localparam int PMA_X  = 2;
  localparam int PMA_AW = 3;

  typedef logic [PMA_AW-1:0] pma_attr_t;

  // A single region still needs a one-bit index port.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pma_region_check_match.sv
// Single-region comparator for the PMA checker.
// A zero base never matches, so base == 0 acts as a second disable.
module pma_region_check_match #(
  parameter int AW = 28
) (
  input  logic [AW-1:0] addr_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW-1:0] mask_i,
  input  logic          en_i,
  output logic          hit_o
);

  assign hit_o = en_i && (base_i != '0) && ((addr_i & mask_i) == base_i);

endmodule

// File: rtl/pma_region_check.sv
// Pipelined PMA lookup: region table, static-priority encoder, one output register.
// Optional feature macro PMA_LOCK_EN adds per-region write locks and port i_cfg_lock.
module pma_region_check
  import pma_region_check_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 28,
  parameter int                       NREGIONS      = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RST_ADDR      = {2'b01, {(ADDRESS_WIDTH-2){1'b0}}},
  parameter logic [ADDRESS_WIDTH-1:0] RST_MASK      = {2'b11, {(ADDRESS_WIDTH-2){1'b0}}},
  parameter pma_attr_t                RST_ATTR      = 3'b111,
  parameter pma_attr_t                DEF_ATTR      = 3'b110,
  localparam int                      AW            = ADDRESS_WIDTH,
  localparam int                      IW            = idxWidth(NREGIONS)
) (
  input  logic          i_clk,
  input  logic          i_areset_n,
  input  logic          i_cfg_we,
  input  logic [IW-1:0] i_cfg_idx,
  input  logic [AW-1:0] i_cfg_base,
  input  logic [AW-1:0] i_cfg_mask,
  input  pma_attr_t     i_cfg_attr,
  input  logic          i_cfg_en,
`ifdef PMA_LOCK_EN
  input  logic          i_cfg_lock,
`endif
  output logic          o_cfg_err,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [AW-1:0] i_req_addr,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [AW-1:0] o_rsp_addr,
  output pma_attr_t     o_rsp_attr,
  output logic          o_rsp_hit,
  output logic [IW-1:0] o_rsp_region
);

  logic [1:0]    rstSync_q;
  logic          rst_n;

  logic [AW-1:0] base_q [NREGIONS];
  logic [AW-1:0] mask_q [NREGIONS];
  pma_attr_t     attr_q [NREGIONS];
  logic [NREGIONS-1:0] en_q;

  logic          idxInRange;
  logic          cfgLocked;
  logic          cfgAccept;
  logic          cfgErr_q;

  logic [NREGIONS-1:0] regionHit;
  logic          anyHit;
  logic [IW-1:0] winIdx;
  pma_attr_t     winAttr;
  logic          reqAccept;

  logic          rspValid_q,  rspValid_d;
  logic [AW-1:0] rspAddr_q,   rspAddr_d;
  pma_attr_t     rspAttr_q,   rspAttr_d;
  logic          rspHit_q,    rspHit_d;
  logic [IW-1:0] rspRegion_q, rspRegion_d;

  // Reset asserts immediately but releases two clocks later, on a clock edge.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) rstSync_q <= 2'b00;
    else             rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rst_n = rstSync_q[1];

  assign idxInRange = 32'(i_cfg_idx) < 32'(NREGIONS);

`ifdef PMA_LOCK_EN
  logic [NREGIONS-1:0] lock_q;

  always_comb begin
    cfgLocked = 1'b0;
    for (int r = 0; r < NREGIONS; r++) begin
      if (32'(i_cfg_idx) == 32'(r)) cfgLocked = lock_q[r];
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= '0;
    end else begin
      for (int r = 0; r < NREGIONS; r++) begin
        if (cfgAccept && i_cfg_lock && (32'(i_cfg_idx) == 32'(r))) lock_q[r] <= 1'b1;
      end
    end
  end
`else
  assign cfgLocked = 1'b0;
`endif

  assign cfgAccept = i_cfg_we && idxInRange && !cfgLocked;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      en_q[0] <= 1'b1;
      for (int r = 0; r < NREGIONS; r++) begin
        base_q[r] <= (r == 0) ? RST_ADDR : '0;
        mask_q[r] <= (r == 0) ? RST_MASK : '0;
        attr_q[r] <= (r == 0) ? RST_ATTR : '0;
      end
    end else begin
      for (int r = 0; r < NREGIONS; r++) begin
        if (cfgAccept && (32'(i_cfg_idx) == 32'(r))) begin
          base_q[r] <= i_cfg_base;
          mask_q[r] <= i_cfg_mask;
          attr_q[r] <= i_cfg_attr;
          en_q[r]   <= i_cfg_en;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) cfgErr_q <= 1'b0;
    else        cfgErr_q <= i_cfg_we && !cfgAccept;
  end

  for (genvar g = 0; g < NREGIONS; g++) begin : gRegion
    pma_region_check_match #(.AW(AW)) uMatch (
      .addr_i (i_req_addr),
      .base_i (base_q[g]),
      .mask_i (mask_q[g]),
      .en_i   (en_q[g]),
      .hit_o  (regionHit[g])
    );
  end

  // Scan from the top down so the lowest matching index is the last to win.
  always_comb begin
    anyHit  = 1'b0;
    winIdx  = '0;
    winAttr = DEF_ATTR;
    for (int r = NREGIONS - 1; r >= 0; r--) begin
      if (regionHit[r]) begin
        anyHit  = 1'b1;
        winIdx  = IW'(r);
        winAttr = attr_q[r];
      end
    end
  end

  assign o_req_ready = !rspValid_q || i_rsp_ready;
  assign reqAccept   = i_req_valid && o_req_ready;

  always_comb begin
    rspValid_d  = rspValid_q;
    rspAddr_d   = rspAddr_q;
    rspAttr_d   = rspAttr_q;
    rspHit_d    = rspHit_q;
    rspRegion_d = rspRegion_q;
    if (reqAccept) begin
      rspValid_d  = 1'b1;
      rspAddr_d   = i_req_addr;
      rspAttr_d   = winAttr;
      rspHit_d    = anyHit;
      rspRegion_d = winIdx;
    end else if (i_rsp_ready) begin
      rspValid_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      rspValid_q  <= 1'b0;
      rspAddr_q   <= '0;
      rspAttr_q   <= '0;
      rspHit_q    <= 1'b0;
      rspRegion_q <= '0;
    end else begin
      rspValid_q  <= rspValid_d;
      rspAddr_q   <= rspAddr_d;
      rspAttr_q   <= rspAttr_d;
      rspHit_q    <= rspHit_d;
      rspRegion_q <= rspRegion_d;
    end
  end

  assign o_cfg_err    = cfgErr_q;
  assign o_rsp_valid  = rspValid_q;
  assign o_rsp_addr   = rspAddr_q;
  assign o_rsp_attr   = rspAttr_q;
  assign o_rsp_hit    = rspHit_q;
  assign o_rsp_region = rspRegion_q;

endmodule

// File: tb/tb_pma_region_check.sv
// Directed testbench for pma_region_check; a second 5-region instance covers out-of-range writes.
// Lock scenarios are exercised only when PMA_LOCK_EN is defined.
module tb_pma_region_check;
  import pma_region_check_pkg::*;

  localparam int AW = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset_n;
  int   checks = 0;
  int   errors = 0;

  logic          cfgWe;
  logic [1:0]    cfgIdx;
  logic [AW-1:0] cfgBase, cfgMask;
  pma_attr_t     cfgAttr;
  logic          cfgEn, cfgErr;
  logic          reqValid, reqReady, rspValid, rspReady, rspHit;
  logic [AW-1:0] reqAddr, rspAddr;
  pma_attr_t     rspAttr;
  logic [1:0]    rspRegion;
  logic [34:0]   rspBus;
`ifdef PMA_LOCK_EN
  logic          cfgLock;
  logic          bLock;
`endif

  logic          bWe;
  logic [2:0]    bIdx;
  logic [AW-1:0] bBase, bMask;
  pma_attr_t     bAttr;
  logic          bEn, bErr;
  logic          bReqValid, bReqReady, bRspValid, bRspReady, bRspHit;
  logic [AW-1:0] bReqAddr, bRspAddr;
  pma_attr_t     bRspAttr;
  logic [2:0]    bRspRegion;
  logic [35:0]   bRspBus;

  assign rspBus  = {rspValid, rspHit, rspRegion, rspAttr, rspAddr};
  assign bRspBus = {bRspValid, bRspHit, bRspRegion, bRspAttr, bRspAddr};

  pma_region_check #(.NREGIONS(4)) dut (
    .i_clk(clk), .i_areset_n(areset_n),
    .i_cfg_we(cfgWe), .i_cfg_idx(cfgIdx), .i_cfg_base(cfgBase), .i_cfg_mask(cfgMask),
    .i_cfg_attr(cfgAttr), .i_cfg_en(cfgEn),
`ifdef PMA_LOCK_EN
    .i_cfg_lock(cfgLock),
`endif
    .o_cfg_err(cfgErr),
    .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_addr(reqAddr),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady), .o_rsp_addr(rspAddr),
    .o_rsp_attr(rspAttr), .o_rsp_hit(rspHit), .o_rsp_region(rspRegion)
  );

  pma_region_check #(.NREGIONS(5)) dutB (
    .i_clk(clk), .i_areset_n(areset_n),
    .i_cfg_we(bWe), .i_cfg_idx(bIdx), .i_cfg_base(bBase), .i_cfg_mask(bMask),
    .i_cfg_attr(bAttr), .i_cfg_en(bEn),
`ifdef PMA_LOCK_EN
    .i_cfg_lock(bLock),
`endif
    .o_cfg_err(bErr),
    .i_req_valid(bReqValid), .o_req_ready(bReqReady), .i_req_addr(bReqAddr),
    .o_rsp_valid(bRspValid), .i_rsp_ready(bRspReady), .o_rsp_addr(bRspAddr),
    .o_rsp_attr(bRspAttr), .o_rsp_hit(bRspHit), .o_rsp_region(bRspRegion)
  );

  // Drives one config write on the main instance for a single cycle.
  task automatic doWrite(input logic [1:0] idx, input logic [AW-1:0] base,
                         input logic [AW-1:0] mask, input pma_attr_t attr,
                         input logic en, input logic lock);
    cfgWe = 1'b1; cfgIdx = idx; cfgBase = base; cfgMask = mask; cfgAttr = attr; cfgEn = en;
`ifdef PMA_LOCK_EN
    cfgLock = lock;
`else
    if (lock) $display("[TB] lock request ignored in this build");
`endif
    @(negedge clk);
    cfgWe = 1'b0;
`ifdef PMA_LOCK_EN
    cfgLock = 1'b0;
`endif
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (rspValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_held got %b want 0", rspValid); end
    areset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rspBus !== 35'd0) begin errors++; $display("[TB] FAIL reset_rsp got %h want 0", rspBus); end
    checks++; if ({reqReady, cfgErr} !== 2'b10) begin errors++; $display("[TB] FAIL reset_ready_err got %b want 10", {reqReady, cfgErr}); end
  endtask

  task automatic test_lookup;
    @(negedge clk);
    reqValid = 1'b1; reqAddr = 28'h4000010; rspReady = 1'b1; #1;
    checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL lookup_ready got %b want 1", reqReady); end
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (rspBus !== {1'b1, 1'b1, 2'd0, 3'b111, 28'h4000010}) begin errors++; $display("[TB] FAIL lookup_r0 got %h want %h", rspBus, {1'b1, 1'b1, 2'd0, 3'b111, 28'h4000010}); end
    @(negedge clk);
    checks++; if (rspValid !== 1'b0) begin errors++; $display("[TB] FAIL lookup_drain got %b want 0", rspValid); end
  endtask

  task automatic test_miss;
    reqValid = 1'b1; reqAddr = 28'h8000000;
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (rspBus !== {1'b1, 1'b0, 2'd0, 3'b110, 28'h8000000}) begin errors++; $display("[TB] FAIL miss got %h want %h", rspBus, {1'b1, 1'b0, 2'd0, 3'b110, 28'h8000000}); end
  endtask

  task automatic test_priority;
    doWrite(2'd1, 28'h8000000, 28'hC000000, 3'b001, 1'b1, 1'b0);
    doWrite(2'd2, 28'h8000000, 28'hF000000, 3'b100, 1'b1, 1'b0);
    checks++; if (cfgErr !== 1'b0) begin errors++; $display("[TB] FAIL prio_cfg_err got %b want 0", cfgErr); end
    reqValid = 1'b1; reqAddr = 28'h8000004;
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (rspBus !== {1'b1, 1'b1, 2'd1, 3'b001, 28'h8000004}) begin errors++; $display("[TB] FAIL prio_r1 got %h want %h", rspBus, {1'b1, 1'b1, 2'd1, 3'b001, 28'h8000004}); end
    doWrite(2'd1, 28'h8000000, 28'hC000000, 3'b001, 1'b0, 1'b0);
    reqValid = 1'b1; reqAddr = 28'h8000004;
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (rspBus !== {1'b1, 1'b1, 2'd2, 3'b100, 28'h8000004}) begin errors++; $display("[TB] FAIL prio_r2 got %h want %h", rspBus, {1'b1, 1'b1, 2'd2, 3'b100, 28'h8000004}); end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] addrs [3];
    logic [34:0]   expRsp [3];
    int sent, recvd;
    addrs[0] = 28'h4000010; addrs[1] = 28'h8000000; addrs[2] = 28'h0000100;
    expRsp[0] = {1'b1, 1'b1, 2'd0, 3'b111, 28'h4000010};
    expRsp[1] = {1'b1, 1'b1, 2'd2, 3'b100, 28'h8000000};
    expRsp[2] = {1'b1, 1'b0, 2'd0, 3'b110, 28'h0000100};
    sent = 0; recvd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      reqValid = (sent < 3);
      reqAddr  = addrs[(sent < 3) ? sent : 2];
      rspReady = (c >= 5);
      #1;
      if (c >= 1 && c <= 4) begin
        checks++; if (reqReady !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall_ready c=%0d got %b want 0", c, reqReady); end
        checks++; if (rspBus !== expRsp[0]) begin errors++; $display("[TB] FAIL b2b_held c=%0d got %h want %h", c, rspBus, expRsp[0]); end
      end
      if (rspValid && rspReady && recvd < 3) begin
        checks++; if (rspBus !== expRsp[recvd]) begin errors++; $display("[TB] FAIL b2b_rsp%0d got %h want %h", recvd, rspBus, expRsp[recvd]); end
        recvd++;
      end
      if (reqValid && reqReady) sent++;
    end
    reqValid = 1'b0;
    checks++; if (recvd !== 3) begin errors++; $display("[TB] FAIL b2b_count got %0d want 3", recvd); end
    checks++; if (rspValid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got %b want 0", rspValid); end
  endtask

  task automatic test_cfg_same_cycle;
    @(negedge clk);
    reqValid = 1'b1; reqAddr = 28'h4000010; rspReady = 1'b1;
    doWrite(2'd0, 28'h0, 28'hC000000, 3'b111, 1'b1, 1'b0);
    reqValid = 1'b0; rspReady = 1'b0;
    checks++; if (rspBus !== {1'b1, 1'b1, 2'd0, 3'b111, 28'h4000010}) begin errors++; $display("[TB] FAIL same_cycle_old got %h want %h", rspBus, {1'b1, 1'b1, 2'd0, 3'b111, 28'h4000010}); end
    @(negedge clk);
    checks++; if (rspBus !== {1'b1, 1'b1, 2'd0, 3'b111, 28'h4000010}) begin errors++; $display("[TB] FAIL no_recompute got %h want %h", rspBus, {1'b1, 1'b1, 2'd0, 3'b111, 28'h4000010}); end
    rspReady = 1'b1;
    @(negedge clk);
    reqValid = 1'b1; reqAddr = 28'h4000010;
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (rspBus !== {1'b1, 1'b0, 2'd0, 3'b110, 28'h4000010}) begin errors++; $display("[TB] FAIL after_write_miss got %h want %h", rspBus, {1'b1, 1'b0, 2'd0, 3'b110, 28'h4000010}); end
  endtask

  task automatic test_cfg_range;
    @(negedge clk);
    bWe = 1'b1; bIdx = 3'd5; bBase = 28'h8000000; bMask = 28'hC000000; bAttr = 3'b001; bEn = 1'b1;
    @(negedge clk);
    bWe = 1'b0;
    checks++; if (bErr !== 1'b1) begin errors++; $display("[TB] FAIL range_err got %b want 1", bErr); end
    @(negedge clk);
    checks++; if (bErr !== 1'b0) begin errors++; $display("[TB] FAIL range_err_pulse got %b want 0", bErr); end
    bReqValid = 1'b1; bReqAddr = 28'h8000004;
    @(negedge clk);
    bReqValid = 1'b0;
    checks++; if (bRspBus !== {1'b1, 1'b0, 3'd0, 3'b110, 28'h8000004}) begin errors++; $display("[TB] FAIL range_unchanged got %h want %h", bRspBus, {1'b1, 1'b0, 3'd0, 3'b110, 28'h8000004}); end
    bWe = 1'b1; bIdx = 3'd4;
    @(negedge clk);
    bWe = 1'b0;
    checks++; if (bErr !== 1'b0) begin errors++; $display("[TB] FAIL inrange_err got %b want 0", bErr); end
    bReqValid = 1'b1;
    @(negedge clk);
    bReqValid = 1'b0;
    checks++; if (bRspBus !== {1'b1, 1'b1, 3'd4, 3'b001, 28'h8000004}) begin errors++; $display("[TB] FAIL inrange_r4 got %h want %h", bRspBus, {1'b1, 1'b1, 3'd4, 3'b001, 28'h8000004}); end
  endtask

  task automatic test_lock_and_reset;
`ifdef PMA_LOCK_EN
    doWrite(2'd1, 28'h8000000, 28'hC000000, 3'b001, 1'b1, 1'b1);
    checks++; if (cfgErr !== 1'b0) begin errors++; $display("[TB] FAIL lock_set_err got %b want 0", cfgErr); end
    doWrite(2'd1, 28'h8000000, 28'hC000000, 3'b010, 1'b1, 1'b0);
    checks++; if (cfgErr !== 1'b1) begin errors++; $display("[TB] FAIL locked_write_err got %b want 1", cfgErr); end
    reqValid = 1'b1; reqAddr = 28'h8000004;
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (rspBus !== {1'b1, 1'b1, 2'd1, 3'b001, 28'h8000004}) begin errors++; $display("[TB] FAIL locked_attr got %h want %h", rspBus, {1'b1, 1'b1, 2'd1, 3'b001, 28'h8000004}); end
`endif
    @(negedge clk);
    reqValid = 1'b1; reqAddr = 28'h4000010; rspReady = 1'b0;
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (rspValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid got %b want 1", rspValid); end
    areset_n = 1'b0; #1;
    checks++; if (rspBus !== 35'd0) begin errors++; $display("[TB] FAIL reset_drop got %h want 0", rspBus); end
    @(negedge clk);
    areset_n = 1'b1; rspReady = 1'b1;
    repeat (3) @(negedge clk);
    reqValid = 1'b1; reqAddr = 28'h4000010;
    @(negedge clk);
    reqAddr = 28'h8000004;
    checks++; if (rspBus !== {1'b1, 1'b1, 2'd0, 3'b111, 28'h4000010}) begin errors++; $display("[TB] FAIL revert_r0 got %h want %h", rspBus, {1'b1, 1'b1, 2'd0, 3'b111, 28'h4000010}); end
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (rspBus !== {1'b1, 1'b0, 2'd0, 3'b110, 28'h8000004}) begin errors++; $display("[TB] FAIL revert_others got %h want %h", rspBus, {1'b1, 1'b0, 2'd0, 3'b110, 28'h8000004}); end
`ifdef PMA_LOCK_EN
    doWrite(2'd1, 28'h8000000, 28'hC000000, 3'b010, 1'b1, 1'b0);
    checks++; if (cfgErr !== 1'b0) begin errors++; $display("[TB] FAIL unlocked_err got %b want 0", cfgErr); end
    reqValid = 1'b1; reqAddr = 28'h8000004;
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (rspBus !== {1'b1, 1'b1, 2'd1, 3'b010, 28'h8000004}) begin errors++; $display("[TB] FAIL unlocked_attr got %h want %h", rspBus, {1'b1, 1'b1, 2'd1, 3'b010, 28'h8000004}); end
`endif
  endtask

  initial begin
    areset_n = 1'b0;
    cfgWe = 1'b0; cfgIdx = '0; cfgBase = '0; cfgMask = '0; cfgAttr = '0; cfgEn = 1'b0;
    reqValid = 1'b0; reqAddr = '0; rspReady = 1'b1;
    bWe = 1'b0; bIdx = '0; bBase = '0; bMask = '0; bAttr = '0; bEn = 1'b0;
    bReqValid = 1'b0; bReqAddr = '0; bRspReady = 1'b1;
`ifdef PMA_LOCK_EN
    cfgLock = 1'b0; bLock = 1'b0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    test_lookup();
    test_miss();
    test_priority();
    test_back_to_back();
    test_cfg_same_cycle();
    test_cfg_range();
    test_lock_and_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
